// File: rtl/instruction_memory.sv
// Instruction memory with a valid/ready fetch port, a two-entry response FIFO
// and an independent program-load write port.
// Fetches read the array on the accepting edge, so a load to the same word on
// that edge is seen only by later fetches.
module instruction_memory #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned ADDR_BITS = 9
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [15:0]          req_addr,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WORD_SIZE-1:0] rsp_data,
   output logic                 rsp_error,
   input  logic                 ld_en,
   input  logic [15:0]          ld_addr,
   input  logic [WORD_SIZE-1:0] ld_data
);

   localparam int unsigned DEPTH = 2 ** (ADDR_BITS - 1);

   logic [WORD_SIZE-1:0] mem [DEPTH];

   logic [1:0]           count_q, count_d;
   logic                 wr_ptr_q, rd_ptr_q;
   logic [WORD_SIZE-1:0] ent_data_q [2];
   logic                 ent_err_q  [2];

   logic                 accept, pop;
   logic                 fetch_err, ld_ok;
   logic [WORD_SIZE-1:0] fetch_data;

   // Handshake, address decode and next occupancy
   always_comb begin
      req_ready  = (count_q != 2'd2);
      rsp_valid  = (count_q != 2'd0);
      rsp_data   = ent_data_q[rd_ptr_q];
      rsp_error  = ent_err_q[rd_ptr_q];
      accept     = req_valid & req_ready;
      pop        = rsp_valid & rsp_ready;
      // Upper address bits must be zero; no wrap-around into the array
      fetch_err  = req_addr[0] | ((req_addr >> ADDR_BITS) != 16'd0);
      fetch_data = fetch_err ? '0 : mem[req_addr[ADDR_BITS-1:1]];
      ld_ok      = ~ld_addr[0] & ((ld_addr >> ADDR_BITS) == 16'd0);
      count_d    = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Response FIFO state; reset discards every pending response
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            ent_data_q[i] <= '0;
            ent_err_q[i]  <= 1'b0;
         end
      end else begin
         count_q <= count_d;
         if (accept) begin
            ent_data_q[wr_ptr_q] <= fetch_data;
            ent_err_q[wr_ptr_q]  <= fetch_err;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   // Program load; array keeps its contents across reset but ignores loads on a reset edge
   always_ff @(posedge clk) begin
      if (reset_n && ld_en && ld_ok) begin
         mem[ld_addr[ADDR_BITS-1:1]] <= ld_data;
      end
   end

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_error;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;

   int n_cmp = 0;
   int n_err = 0;

   instruction_memory #(.WORD_SIZE(16), .ADDR_BITS(9)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_error (rsp_error),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Present one fetch for exactly one edge (caller guarantees req_ready)
   task automatic issue(input logic [15:0] a);
      req_valid = 1'b1; req_addr = a;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; ld_en = 1'b0;
      req_addr = 16'h0; ld_addr = 16'h0; ld_data = 16'h0;
      tick(); tick();
      reset_n = 1'b1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      n_cmp++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
      n_cmp++; if (rsp_error !== 1'b0) begin n_err++; $display("FAIL reset_rsp_error: got %b expected 0", rsp_error); end
   endtask

   task automatic test_basic();
      do_load(16'h0000, 16'h1234);
      do_load(16'h0002, 16'hABCD);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 16'h0000;
      tick();
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid0: got %b expected 1", rsp_valid); end
      n_cmp++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL basic_data0: got %h expected 1234", rsp_data); end
      n_cmp++; if (rsp_error !== 1'b0) begin n_err++; $display("FAIL basic_err0: got %b expected 0", rsp_error); end
      req_addr = 16'h0002;
      tick();
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid1: got %b expected 1", rsp_valid); end
      n_cmp++; if (rsp_data !== 16'hABCD) begin n_err++; $display("FAIL basic_data1: got %h expected abcd", rsp_data); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 16'h0000;
      tick();
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b expected 1", req_ready); end
      req_addr = 16'h0002;
      tick();
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2: got %b expected 0", req_ready); end
      n_cmp++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL bp_head: got %h expected 1234", rsp_data); end
      req_addr = 16'h0000;
      tick();
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall: got %b expected 0", req_ready); end
      n_cmp++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL bp_hold: got %h expected 1234", rsp_data); end
      rsp_ready = 1'b1;
      tick();
      n_cmp++; if (rsp_data !== 16'hABCD) begin n_err++; $display("FAIL bp_second: got %h expected abcd", rsp_data); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen: got %b expected 1", req_ready); end
      tick();
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_third_valid: got %b expected 1", rsp_valid); end
      n_cmp++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL bp_third: got %h expected 1234", rsp_data); end
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_errors();
      rsp_ready = 1'b1;
      do_load(16'h01FE, 16'h5555);
      do_load(16'h0200, 16'h7777);
      do_load(16'h0001, 16'h8888);
      issue(16'h0003);
      n_cmp++; if (rsp_error !== 1'b1) begin n_err++; $display("FAIL misalign_err: got %b expected 1", rsp_error); end
      n_cmp++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL misalign_data: got %h expected 0000", rsp_data); end
      issue(16'h0200);
      n_cmp++; if (rsp_error !== 1'b1) begin n_err++; $display("FAIL oor_err: got %b expected 1", rsp_error); end
      n_cmp++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL oor_data: got %h expected 0000", rsp_data); end
      issue(16'h01FE);
      n_cmp++; if (rsp_error !== 1'b0) begin n_err++; $display("FAIL last_err: got %b expected 0", rsp_error); end
      n_cmp++; if (rsp_data !== 16'h5555) begin n_err++; $display("FAIL last_data: got %h expected 5555", rsp_data); end
      issue(16'h0000);
      n_cmp++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL bad_load_ignored: got %h expected 1234", rsp_data); end
      tick();
   endtask

   task automatic test_same_edge();
      rsp_ready = 1'b1;
      ld_en = 1'b1; ld_addr = 16'h0000; ld_data = 16'h9999;
      issue(16'h0000);
      ld_en = 1'b0;
      n_cmp++; if (rsp_data !== 16'h1234) begin n_err++; $display("FAIL same_edge_old: got %h expected 1234", rsp_data); end
      issue(16'h0000);
      n_cmp++; if (rsp_data !== 16'h9999) begin n_err++; $display("FAIL same_edge_new: got %h expected 9999", rsp_data); end
      tick();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      issue(16'h0000);
      issue(16'h0002);
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rm_full: got %b expected 0", req_ready); end
      reset_n = 1'b0;
      ld_en = 1'b1; ld_addr = 16'h0002; ld_data = 16'h4444;
      tick();
      reset_n = 1'b1; ld_en = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b expected 0", rsp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b expected 1", req_ready); end
      tick(); tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_stale: got %b expected 0", rsp_valid); end
      rsp_ready = 1'b1;
      issue(16'h0002);
      n_cmp++; if (rsp_data !== 16'hABCD) begin n_err++; $display("FAIL rm_retained: got %h expected abcd", rsp_data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         req_addr = (i % 2 == 1) ? 16'h0002 : 16'h0000;
         exp      = (i % 2 == 1) ? 16'hABCD : 16'h9999;
         tick();
         n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, rsp_valid); end
         n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stream_count[%0d]: req_ready got %b expected 1", i, req_ready); end
         n_cmp++; if (rsp_data !== exp) begin n_err++; $display("FAIL stream_data[%0d]: got %h expected %h", i, rsp_data, exp); end
      end
      req_valid = 1'b0;
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b expected 0", rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_errors();
      test_same_edge();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
